// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, widths and twiddle generation for the FFT rotator sequencer
package fft_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int TWIDDLE_WIDTH = 16;
  localparam int TW_MAX        = (1 << (TWIDDLE_WIDTH - 1)) - 1;

  typedef struct packed {
    logic signed [TWIDDLE_WIDTH-1:0] cos;
    logic signed [TWIDDLE_WIDTH-1:0] sin;
  } twiddle_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IM   = 2'd1,
    S_RE   = 2'd2
  } rot_ctrl_state_t;

  localparam twiddle_t TW_UNITY = {TWIDDLE_WIDTH'(TW_MAX), TWIDDLE_WIDTH'(0)};

  // Round half away from zero so positive and negative twiddles stay symmetric.
  function automatic int round_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(0.5 - x);
  endfunction

  function automatic twiddle_t tw_value(input int e, input int n_pts);
    real ang;
    twiddle_t t;
    ang   = 2.0 * 3.14159265358979323846 * $itor(e) / $itor(n_pts);
    t.cos = TWIDDLE_WIDTH'(round_real($cos(ang) * $itor(TW_MAX)));
    t.sin = TWIDDLE_WIDTH'(round_real(-$sin(ang) * $itor(TW_MAX)));
    return t;
  endfunction

endpackage

// File: rtl/fft_rot_ctrl_twiddle_rom.sv
// rtl/fft_rot_ctrl_twiddle_rom.sv - registered-read twiddle table for the upper half of one butterfly span
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int STAGE    = 0,
  localparam int HALF    = (N_POINTS >> STAGE) / 2,
  localparam int AW      = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output twiddle_t      data
);

  twiddle_t rom [2**AW];

  // Entry i holds exponent i << STAGE; unreachable padding entries hold unity.
  for (genvar i = 0; i < 2**AW; i++) begin : g_rom
    if (i < HALF) begin : g_used
      assign rom[i] = tw_value(i << STAGE, N_POINTS);
    end else begin : g_pad
      assign rom[i] = TW_UNITY;
    end
  end

  always_ff @(posedge clk) begin
    if (en) data <= rom[addr];
  end

endmodule

// File: rtl/fft_rot_ctrl.sv
// rtl/fft_rot_ctrl.sv - twiddle rotator sequencer for one radix-2 SDF stage
// Optional framing-error checking enabled by defining FFT_ROTCTRL_CHECK_EN.
module fft_rot_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int STAGE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] rot_din,
  output logic                  rot_sw,
  output twiddle_t              rot_twiddle,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  err
);

  localparam int NW   = $clog2(N_POINTS);
  localparam int LW   = NW - STAGE;
  localparam int HALF = (N_POINTS >> STAGE) / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  rot_ctrl_state_t state, state_next;
  logic [NW-1:0]   n, n_eff;
  logic            accept_re, accept_im, restart, err_set, last_sample;
  logic [AW-1:0]   rom_addr;
  twiddle_t        rom_data;
  logic            upper_q, eop_pend;

  assign last_sample = (n == NW'(N_POINTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid && in_sop) state_next = S_IM;
      S_IM:    state_next = (in_valid && !last_sample) ? S_RE : S_IDLE;
      S_RE:    if (in_valid) state_next = S_IM;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept_re = 1'b0;
    accept_im = 1'b0;
    restart   = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: if (in_valid && in_sop) begin
        accept_re = 1'b1;
        restart   = 1'b1;
      end
      S_IM: begin
        accept_im = in_valid;
        err_set   = !in_valid || in_sop;
      end
      S_RE: if (in_valid) begin
        accept_re = 1'b1;
        restart   = in_sop;
        err_set   = in_sop;
      end
      default: ;
    endcase
  end

  // The ROM address follows the sample index the real word belongs to.
  assign n_eff    = restart ? '0 : n;
  assign rom_addr = AW'(n_eff & NW'(HALF - 1));

  twiddle_rom #(
    .N_POINTS (N_POINTS),
    .STAGE    (STAGE)
  ) u_rom (
    .clk  (clk),
    .en   (accept_re),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n           <= '0;
      upper_q     <= 1'b0;
      rot_din     <= '0;
      rot_sw      <= 1'b0;
      rot_twiddle <= TW_UNITY;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      eop_pend    <= 1'b0;
      out_eop     <= 1'b0;
    end else begin
      rot_din   <= in_data;
      rot_sw    <= accept_im;
      out_valid <= accept_im || rot_sw;
      out_sop   <= accept_im && (n == '0);
      eop_pend  <= accept_im && last_sample;
      out_eop   <= eop_pend;
      if (accept_re) begin
        upper_q <= n_eff[LW-1];
        if (restart) n <= '0;
      end
      // Twiddle moves only with the imaginary word, so it is stable for both output words.
      if (accept_im) begin
        n           <= n + NW'(1);
        rot_twiddle <= upper_q ? rom_data : TW_UNITY;
      end
    end
  end

`ifdef FFT_ROTCTRL_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`else
  logic unused_err_set;
  assign unused_err_set = err_set;
  assign err            = 1'b0;
`endif

endmodule
